// File: rtl/inst_fetch_mod_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// immediate-length codes and boot defaults.
package fetch_pkg;

  // FSM state encodings kept as plain constants for legacy tooling.
  localparam logic [2:0] FETCH_OP = 3'd0;
  localparam logic [2:0] FETCH_CB = 3'd1;
  localparam logic [2:0] FETCH_LO = 3'd2;
  localparam logic [2:0] FETCH_HI = 3'd3;
  localparam logic [2:0] READY    = 3'd4;

  typedef logic [1:0] imm_len_t;
  localparam imm_len_t IMM_NONE = 2'd0;
  localparam imm_len_t IMM_BYTE = 2'd1;
  localparam imm_len_t IMM_WORD = 2'd2;

  localparam logic [7:0]  CB_PREFIX_DEFAULT = 8'hCB;
  localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;

  // Next fetch address; the 16-bit add wraps FFFF to 0000 naturally.
  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/inst_fetch_mod_if.sv
// Bus bundle between the fetch unit (master), the memory bus and the
// control unit (slave side).
interface inst_fetch_mod_if;
  import fetch_pkg::*;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic [7:0]  inst_buffer;
  logic        inst_cb;
  logic [15:0] imm_data;
  logic        inst_adv;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_buffer, inst_cb, imm_data, pc,
    input  mem_ack, mem_rdata, inst_adv, pc_load, pc_load_value
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_buffer, inst_cb, imm_data, pc,
    output mem_ack, mem_rdata, inst_adv, pc_load, pc_load_value
  );
endinterface

// File: rtl/inst_fetch_mod_len_decode.sv
// Combinational immediate-length decode for unprefixed opcodes.
module inst_len_decode
  import fetch_pkg::*;
(
  input  logic [7:0] i_opcode,
  output imm_len_t   o_imm_len
);

  // Map each opcode to the number of immediate bytes that follow it.
  always_comb begin
    o_imm_len = IMM_NONE;
    case (i_opcode)
      8'h06, 8'h0E, 8'h10, 8'h16, 8'h18, 8'h1E, 8'h20, 8'h26,
      8'h28, 8'h2E, 8'h30, 8'h36, 8'h38, 8'h3E, 8'hC6, 8'hCE,
      8'hD6, 8'hDE, 8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6,
      8'hF8, 8'hFE:
        o_imm_len = IMM_BYTE;
      8'h01, 8'h08, 8'h11, 8'h21, 8'h31, 8'hC2, 8'hC3, 8'hC4,
      8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA,
      8'hFA:
        o_imm_len = IMM_WORD;
      default:
        o_imm_len = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/inst_fetch_mod.sv
// Instruction fetch unit: pulls opcode, optional CB byte and immediates
// one byte at a time and presents a complete instruction to control.
module inst_fetch_mod
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [7:0]  CB_PREFIX = CB_PREFIX_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  inst_fetch_mod_if.master bus
);

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_inst_buffer;
  logic        r_inst_cb;
  logic [15:0] r_imm_data;

  logic        w_mem_req;
  logic        w_accept;
  logic [7:0]  w_dec_opcode;
  imm_len_t    w_imm_len;

  // Requests are masked during reset so the bus sees nothing mid-reset.
  assign w_mem_req = !reset && (r_state != READY);
  assign w_accept  = w_mem_req && bus.mem_ack;

  // In FETCH_OP the incoming byte is the opcode; afterwards the latched
  // opcode still selects between one and two immediate bytes.
  assign w_dec_opcode = (r_state == FETCH_OP) ? bus.mem_rdata : r_inst_buffer;

  inst_len_decode u_len_decode (
    .i_opcode  (w_dec_opcode),
    .o_imm_len (w_imm_len)
  );

  // Sequence state and fetch address; redirect beats any accepted byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH_OP;
      r_pc    <= RESET_PC;
    end else if (bus.pc_load) begin
      r_state <= FETCH_OP;
      r_pc    <= bus.pc_load_value;
    end else begin
      if (w_accept) r_pc <= pc_next(r_pc);
      case (r_state)
        FETCH_OP: begin
          if (w_accept) begin
            if (bus.mem_rdata == CB_PREFIX)  r_state <= FETCH_CB;
            else if (w_imm_len == IMM_NONE)  r_state <= READY;
            else                             r_state <= FETCH_LO;
          end
        end
        FETCH_CB: if (w_accept) r_state <= READY;
        FETCH_LO: if (w_accept) r_state <= (w_imm_len == IMM_WORD) ? FETCH_HI : READY;
        FETCH_HI: if (w_accept) r_state <= READY;
        READY:    if (bus.inst_adv) r_state <= FETCH_OP;
        default:  r_state <= FETCH_OP;
      endcase
    end
  end

  // Instruction fields, held steady while the instruction is presented.
  always_ff @(posedge clock) begin
    if (reset || bus.pc_load) begin
      r_inst_buffer <= 8'h00;
      r_inst_cb     <= 1'b0;
      r_imm_data    <= 16'h0000;
    end else begin
      case (r_state)
        FETCH_OP: begin
          if (w_accept) begin
            r_inst_buffer <= bus.mem_rdata;
            r_inst_cb     <= 1'b0;
            r_imm_data    <= 16'h0000;
          end
        end
        FETCH_CB: begin
          if (w_accept) begin
            r_inst_buffer <= bus.mem_rdata;
            r_inst_cb     <= 1'b1;
          end
        end
        FETCH_LO: if (w_accept) r_imm_data <= {8'h00, bus.mem_rdata};
        FETCH_HI: if (w_accept) r_imm_data[15:8] <= bus.mem_rdata;
        READY: begin
          if (bus.inst_adv) begin
            r_inst_cb  <= 1'b0;
            r_imm_data <= 16'h0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = r_pc;
  assign bus.pc          = r_pc;
  assign bus.inst_valid  = !reset && (r_state == READY);
  assign bus.inst_buffer = r_inst_buffer;
  assign bus.inst_cb     = r_inst_cb;
  assign bus.imm_data    = r_imm_data;

endmodule

// File: tb/tb_inst_fetch_mod.sv
// Bench for inst_fetch_mod: directed cycle table, latency sequences and a
// randomized run against an instruction-level reference model.
module tb_inst_fetch_mod;

  logic clock = 1'b0;
  logic reset;

  inst_fetch_mod_if bus();

  inst_fetch_mod dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst, ack, adv, ld;
    logic [15:0] ldv;
    logic        ev, ereq, ecb;
    logic [7:0]  ebuf;
    logic [15:0] eimm, epc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic rst, ack, adv, ld, input logic [15:0] ldv,
                     input logic ev, ereq, ecb, input logic [7:0] ebuf,
                     input logic [15:0] eimm, epc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.adv = adv; v.ld = ld; v.ldv = ldv;
    v.ev = ev; v.ereq = ereq; v.ecb = ecb; v.ebuf = ebuf; v.eimm = eimm; v.epc = epc;
    tbl.push_back(v);
  endtask

  // Immediate byte count taken straight from the opcode lists.
  function automatic int imm_len(input logic [7:0] op);
    if (op inside {8'h06, 8'h0E, 8'h10, 8'h16, 8'h18, 8'h1E, 8'h20, 8'h26,
                   8'h28, 8'h2E, 8'h30, 8'h36, 8'h38, 8'h3E, 8'hC6, 8'hCE,
                   8'hD6, 8'hDE, 8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6,
                   8'hF8, 8'hFE}) return 1;
    if (op inside {8'h01, 8'h08, 8'h11, 8'h21, 8'h31, 8'hC2, 8'hC3, 8'hC4,
                   8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA,
                   8'hFA}) return 2;
    return 0;
  endfunction

  // Whole instruction starting at address s, as the control unit should see it.
  task automatic ref_inst(input logic [15:0] s, output logic [7:0] ibuf,
                          output logic icb, output logic [15:0] imm,
                          output logic [15:0] next_pc);
    logic [7:0] op;
    int n;
    op = mem[s];
    if (op == 8'hCB) begin
      ibuf = mem[16'(s + 1)]; icb = 1'b1; imm = 16'h0000; next_pc = 16'(s + 2);
    end else begin
      n = imm_len(op);
      ibuf = op; icb = 1'b0;
      if (n == 0)      imm = 16'h0000;
      else if (n == 1) imm = {8'h00, mem[16'(s + 1)]};
      else             imm = {mem[16'(s + 2)], mem[16'(s + 1)]};
      next_pc = 16'(s + 1 + n);
    end
  endtask

  initial begin
    int lat;
    logic [15:0] exp_pc, start, prev_addr;
    logic prev_stall, after_load, req_now, valid_now;
    logic [7:0] e_buf;
    logic e_cb;
    logic [15:0] e_imm, e_next;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0100] = 8'h31; mem[16'h0101] = 8'hFE; mem[16'h0102] = 8'hFF;
    mem[16'h0103] = 8'hCB; mem[16'h0104] = 8'h7C;
    mem[16'h0105] = 8'h3E; mem[16'h0106] = 8'h5A;
    mem[16'h0107] = 8'hC3; mem[16'h0108] = 8'h34; mem[16'h0109] = 8'h12;
    mem[16'h0200] = 8'hC3;

    reset = 1'b1;
    bus.mem_ack = 1'b1; bus.inst_adv = 1'b0; bus.pc_load = 1'b0; bus.pc_load_value = 16'h0;

    //   rst ack adv ld  ldv       v  req cb  buf    imm       pc
    add(1, 1, 0, 0, 16'h0000,   0, 0, 0, 8'h00, 16'h0000, 16'h0000);
    add(1, 1, 0, 0, 16'h0000,   0, 0, 0, 8'h00, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h0000,   1, 0, 0, 8'h00, 16'h0000, 16'h0001);
    add(0, 1, 0, 0, 16'h0000,   1, 0, 0, 8'h00, 16'h0000, 16'h0001);
    add(0, 1, 0, 1, 16'h0100,   0, 1, 0, 8'h00, 16'h0000, 16'h0100);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'h31, 16'h0000, 16'h0101);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'h31, 16'h00FE, 16'h0102);
    add(0, 1, 0, 0, 16'h0000,   1, 0, 0, 8'h31, 16'hFFFE, 16'h0103);
    add(0, 1, 1, 0, 16'h0000,   0, 1, 0, 8'h31, 16'h0000, 16'h0103);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'hCB, 16'h0000, 16'h0104);
    add(0, 1, 0, 0, 16'h0000,   1, 0, 1, 8'h7C, 16'h0000, 16'h0105);
    add(0, 1, 1, 0, 16'h0000,   0, 1, 0, 8'h7C, 16'h0000, 16'h0105);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'h3E, 16'h0000, 16'h0106);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 8'h3E, 16'h0000, 16'h0106);
    add(0, 0, 1, 0, 16'h0000,   0, 1, 0, 8'h3E, 16'h0000, 16'h0106);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 8'h3E, 16'h0000, 16'h0106);
    add(0, 1, 0, 0, 16'h0000,   1, 0, 0, 8'h3E, 16'h005A, 16'h0107);
    add(0, 1, 1, 0, 16'h0000,   0, 1, 0, 8'h3E, 16'h0000, 16'h0107);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'hC3, 16'h0000, 16'h0108);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'hC3, 16'h0034, 16'h0109);
    add(0, 1, 0, 1, 16'h0038,   0, 1, 0, 8'h00, 16'h0000, 16'h0038);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 8'h00, 16'h0000, 16'h0038);
    add(0, 0, 0, 1, 16'hFFFF,   0, 1, 0, 8'h00, 16'h0000, 16'hFFFF);
    add(0, 1, 0, 0, 16'h0000,   1, 0, 0, 8'h00, 16'h0000, 16'h0000);
    add(0, 1, 1, 1, 16'h0200,   0, 1, 0, 8'h00, 16'h0000, 16'h0200);
    add(0, 1, 0, 0, 16'h0000,   0, 1, 0, 8'hC3, 16'h0000, 16'h0201);
    add(1, 1, 0, 1, 16'h1234,   0, 0, 0, 8'h00, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 8'h00, 16'h0000, 16'h0000);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; bus.mem_ack = tbl[i].ack; bus.inst_adv = tbl[i].adv;
      bus.pc_load = tbl[i].ld; bus.pc_load_value = tbl[i].ldv;
      step();
      chk($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d mem_req", i), 32'(bus.mem_req), 32'(tbl[i].ereq));
      chk($sformatf("row%0d inst_cb", i), 32'(bus.inst_cb), 32'(tbl[i].ecb));
      chk($sformatf("row%0d inst_buffer", i), 32'(bus.inst_buffer), 32'(tbl[i].ebuf));
      chk($sformatf("row%0d imm_data", i), 32'(bus.imm_data), 32'(tbl[i].eimm));
      chk($sformatf("row%0d pc", i), 32'(bus.pc), 32'(tbl[i].epc));
      if (tbl[i].ereq) chk($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].epc));
    end

    // Latency with mem_ack tied high: 3-byte instruction, then 1-byte.
    bus.mem_ack = 1'b1; bus.inst_adv = 1'b0;
    bus.pc_load = 1'b1; bus.pc_load_value = 16'h0100;
    step();
    bus.pc_load = 1'b0;
    lat = 1;
    while (!bus.inst_valid && lat < 20) begin step(); lat++; end
    chk("latency 3-byte", 32'(lat), 32'd4);
    bus.pc_load = 1'b1; bus.pc_load_value = 16'h0000;
    step();
    bus.pc_load = 1'b0;
    lat = 1;
    while (!bus.inst_valid && lat < 20) begin step(); lat++; end
    chk("latency 1-byte", 32'(lat), 32'd2);

    // Randomized run against the instruction-level model.
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    bus.mem_ack = 1'b0; bus.inst_adv = 1'b0;
    bus.pc_load = 1'b1; bus.pc_load_value = 16'($urandom);
    exp_pc = bus.pc_load_value; start = exp_pc;
    step();
    after_load = 1'b1; prev_stall = 1'b0; prev_addr = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd pc", 32'(bus.pc), 32'(exp_pc));
      if (bus.mem_req) chk("rnd mem_addr", 32'(bus.mem_addr), 32'(bus.pc));
      if (prev_stall) chk("rnd stall addr", 32'(bus.mem_addr), 32'(prev_addr));
      if (after_load) chk("rnd valid after load", 32'(bus.inst_valid), 32'd0);
      if (bus.inst_valid) begin
        ref_inst(start, e_buf, e_cb, e_imm, e_next);
        chk("rnd inst_buffer", 32'(bus.inst_buffer), 32'(e_buf));
        chk("rnd inst_cb", 32'(bus.inst_cb), 32'(e_cb));
        chk("rnd imm_data", 32'(bus.imm_data), 32'(e_imm));
        chk("rnd pc at ready", 32'(bus.pc), 32'(e_next));
      end
      bus.mem_ack = ($urandom_range(0, 2) != 0);
      bus.inst_adv = $urandom_range(0, 1);
      bus.pc_load = ($urandom_range(0, 39) == 0);
      bus.pc_load_value = 16'($urandom);
      req_now = bus.mem_req; valid_now = bus.inst_valid;
      prev_addr = bus.mem_addr;
      step();
      if (bus.pc_load) begin
        exp_pc = bus.pc_load_value; start = exp_pc;
        after_load = 1'b1; prev_stall = 1'b0;
      end else begin
        after_load = 1'b0;
        prev_stall = req_now && !bus.mem_ack;
        if (req_now && bus.mem_ack) exp_pc = 16'(exp_pc + 1);
        if (valid_now && bus.inst_adv) start = exp_pc;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_mod.md
INST_FETCH_MOD -- requirements
Module: inst_fetch_mod

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset (boot ROM entry).
REQ-002 Parameter CB_PREFIX, default 8'hCB, SHALL be the opcode byte treated as the extended-opcode prefix.
REQ-003 Port clock, input, 1 bit: system clock; all state SHALL change on its rising edge only.
REQ-004 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port mem_req, output, 1 bit: byte read request to the memory bus.
REQ-006 Port mem_addr, output, 16 bits: read address; SHALL equal pc whenever mem_req=1.
REQ-007 Port mem_ack, input, 1 bit: read data valid; byte accepted on a cycle with mem_req=1 and mem_ack=1.
REQ-008 Port mem_rdata, input, 8 bits: read data, sampled only on an accepted cycle.
REQ-009 Port inst_valid, output, 1 bit: a complete instruction is presented to the control unit.
REQ-010 Port inst_buffer, output, 8 bits: opcode byte; the second byte for CB-prefixed instructions.
REQ-011 Port inst_cb, output, 1 bit: the presented instruction is CB-prefixed.
REQ-012 Port imm_data, output, 16 bits: immediate operand; imm8 in [7:0] with [15:8]=0; imm16 little-endian.
REQ-013 Port inst_adv, input, 1 bit: control unit has consumed the presented instruction.
REQ-014 Port pc_load, input, 1 bit: redirect fetch (jump/call/ret/interrupt).
REQ-015 Port pc_load_value, input, 16 bits: new PC, sampled when pc_load=1.
REQ-016 Port pc, output, 16 bits: address of the next byte to fetch.

Function
REQ-017 The FSM SHALL have the states FETCH_OP, FETCH_CB, FETCH_LO, FETCH_HI and READY.
REQ-018 mem_req SHALL be 1 in all states except READY and SHALL stay asserted, with mem_addr stable, until mem_ack.
REQ-019 Each accepted byte SHALL increment pc by 1, wrapping 16'hFFFF to 16'h0000.
REQ-020 FETCH_OP accept SHALL transition: byte=CB_PREFIX -> FETCH_CB; imm length 0 -> READY; imm length 1 or 2 -> FETCH_LO.
REQ-021 FETCH_CB accept SHALL latch the byte into inst_buffer, set inst_cb=1, and go to READY; CB opcodes never carry immediates.
REQ-022 FETCH_LO accept SHALL latch imm_data[7:0] and go to READY for imm length 1, or to FETCH_HI for imm length 2.
REQ-023 FETCH_HI accept SHALL latch imm_data[15:8] and go to READY.
REQ-024 Imm length 1 SHALL apply to opcodes 06,0E,10,16,18,1E,20,26,28,2E,30,36,38,3E,C6,CE,D6,DE,E0,E6,E8,EE,F0,F6,F8,FE.
REQ-025 Imm length 2 SHALL apply to opcodes 01,08,11,21,31,C2,C3,C4,CA,CC,CD,D2,D4,DA,DC,EA,FA; all other opcodes SHALL have imm length 0.
REQ-026 inst_valid SHALL be 1 exactly in READY; inst_buffer, inst_cb and imm_data SHALL be stable throughout READY.
REQ-027 inst_adv in READY SHALL move the FSM to FETCH_OP on the next cycle, clear inst_cb and clear imm_data.
REQ-028 inst_adv outside READY SHALL be ignored.
REQ-029 pc_load=1 in any state SHALL, next cycle, set pc=pc_load_value, set state=FETCH_OP, clear inst_valid and discard any partial instruction.
REQ-030 When pc_load and mem_ack coincide, pc_load SHALL win: the byte is dropped and pc is not incremented.
REQ-031 pc_load SHALL take priority over a simultaneous inst_adv.
REQ-032 Minimum latency from fetch start to inst_valid SHALL be 1 + (bytes - 1) + 1 cycles with mem_ack tied high (e.g. 2 cycles for a 1-byte instruction).

Reset
REQ-033 reset SHALL set pc=RESET_PC, state=FETCH_OP, inst_buffer=8'h00, inst_cb=0 and imm_data=16'h0000.
REQ-034 During reset cycles, inst_valid=0 and mem_req=0; reset SHALL override pc_load and mem_ack, including mid-instruction.

Structure
REQ-035 The FSM state encodings, CB_PREFIX and RESET_PC default SHALL live in a shared package (fetch_pkg).
REQ-036 Imm-length decode SHALL be the combinational sub-module inst_len_decode (8-bit opcode in, 2-bit length out).

Verification
REQ-037 Reset with mem_ack=1 and byte 00 at 0000: inst_valid rises 2 cycles after reset drops, inst_buffer=00, pc=0001.
REQ-038 Bytes 31 FE FF at 0100, mem_ack=1: inst_buffer=31, imm_data=FFFE, pc=0103, inst_valid after 4 cycles.
REQ-039 Bytes CB 7C: inst_cb=1 and inst_buffer=7C; after inst_adv, inst_cb=0 and a fetch begins at pc+2.
REQ-040 Byte 3E with mem_ack withheld 3 cycles on the imm: mem_addr is held constant, then imm_data=00xx.
REQ-041 pc_load=1 with value 0038 on the same cycle as mem_ack during FETCH_HI: byte dropped, pc=0038, inst_valid=0.
REQ-042 pc=FFFF with byte 00: after the accept, pc=0000.
